// File: rtl/mssd_frame_tx.sv
// rtl/mssd_frame_tx.sv - serial frame generator for the mssd demultiplexer input
module mssd_frame_tx #(
    parameter int PORT_W    = 2,
    parameter int CNT_W     = 6,
    parameter int IDLE_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [PORT_W-1:0] cmd_port,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [7:0]        byte_data,
    output logic              s_out,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_PORT,
        ST_CNT,
        ST_DATA,
        ST_GAP
    } state_t;

    // One shared bit counter serves the port, count, data and gap fields.
    localparam int BC_W = 16;
    localparam logic [BC_W-1:0] PORT_LAST = BC_W'(PORT_W - 1);
    localparam logic [BC_W-1:0] CNT_LAST  = BC_W'(CNT_W - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(7);
    localparam logic [BC_W-1:0] GAP_LAST  = BC_W'(IDLE_BITS - 1);
    // Wraps to all ones when IDLE_BITS==1, so it never matches; that case
    // raises frame_done on gap entry instead.
    localparam logic [BC_W-1:0] GAP_DONE  = BC_W'(IDLE_BITS - 2);

    state_t            state_q, state_d;
    logic              s_out_q, s_out_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              underrun_q, underrun_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [CNT_W-1:0]  cnt_sh_q, cnt_sh_d;
    logic [7:0]        data_sh_q, data_sh_d;
    logic [CNT_W-1:0]  byte_left_q, byte_left_d;
    logic [CNT_W-1:0]  fetch_left_q, fetch_left_d;
    logic              buf_full_q, buf_full_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              aborted_q, aborted_d;
    logic              need_byte;
    logic              to_gap;
    logic              fetch;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign byte_ready = ~buf_full_q && (fetch_left_q != '0) &&
                        (state_q inside {ST_START, ST_PORT, ST_CNT, ST_DATA});
    assign fetch      = byte_valid & byte_ready;

    assign s_out      = s_out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    // Next-state, next line bit and byte buffer bookkeeping.
    always_comb begin
        state_d      = state_q;
        s_out_d      = 1'b1;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        cnt_d        = cnt_q;
        port_d       = port_q;
        cnt_sh_d     = cnt_sh_q;
        data_sh_d    = data_sh_q;
        byte_left_d  = byte_left_q;
        fetch_left_d = fetch_left_q;
        buf_full_d   = buf_full_q;
        buf_data_d   = buf_data_q;
        aborted_d    = aborted_q;
        need_byte    = 1'b0;
        to_gap       = 1'b0;

        if (fetch) begin
            buf_full_d   = 1'b1;
            buf_data_d   = byte_data;
            fetch_left_d = fetch_left_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d      = ST_START;
                    s_out_d      = 1'b0;
                    port_d       = cmd_port;
                    cnt_sh_d     = cmd_count;
                    byte_left_d  = cmd_count;
                    fetch_left_d = cmd_count;
                    buf_full_d   = 1'b0;
                    aborted_d    = 1'b0;
                    cnt_d        = '0;
                end
            end
            ST_START: begin
                state_d = ST_PORT;
                s_out_d = port_q[0];
                port_d  = port_q >> 1;
                cnt_d   = '0;
            end
            ST_PORT: begin
                if (cnt_q == PORT_LAST) begin
                    state_d  = ST_CNT;
                    s_out_d  = cnt_sh_q[0];
                    cnt_sh_d = cnt_sh_q >> 1;
                    cnt_d    = '0;
                end else begin
                    s_out_d = port_q[0];
                    port_d  = port_q >> 1;
                    cnt_d   = cnt_q + BC_W'(1);
                end
            end
            ST_CNT: begin
                if (cnt_q == CNT_LAST) begin
                    if (byte_left_q == '0) begin
                        to_gap = 1'b1;
                    end else begin
                        need_byte = 1'b1;
                    end
                end else begin
                    s_out_d  = cnt_sh_q[0];
                    cnt_sh_d = cnt_sh_q >> 1;
                    cnt_d    = cnt_q + BC_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    if (byte_left_q == '0) begin
                        to_gap = 1'b1;
                    end else begin
                        need_byte = 1'b1;
                    end
                end else begin
                    s_out_d   = data_sh_q[0];
                    data_sh_d = data_sh_q >> 1;
                    cnt_d     = cnt_q + BC_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d        = cnt_q + BC_W'(1);
                    frame_done_d = (cnt_q == GAP_DONE) && !aborted_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_gap) begin
            state_d      = ST_GAP;
            cnt_d        = '0;
            frame_done_d = (IDLE_BITS == 1);
        end

        // Start of a new byte: move the buffer into the shifter, or abort
        // the frame when the byte has not arrived in time.
        if (need_byte) begin
            if (buf_full_q) begin
                state_d     = ST_DATA;
                s_out_d     = buf_data_q[0];
                data_sh_d   = {1'b0, buf_data_q[7:1]};
                buf_full_d  = 1'b0;
                byte_left_d = byte_left_q - CNT_W'(1);
                cnt_d       = '0;
            end else begin
                state_d      = ST_GAP;
                cnt_d        = '0;
                underrun_d   = 1'b1;
                aborted_d    = 1'b1;
                fetch_left_d = '0;
                byte_left_d  = '0;
                buf_full_d   = 1'b0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset returns the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_out_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            cnt_q        <= '0;
            port_q       <= '0;
            cnt_sh_q     <= '0;
            data_sh_q    <= '0;
            byte_left_q  <= '0;
            fetch_left_q <= '0;
            buf_full_q   <= 1'b0;
            buf_data_q   <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_out_q      <= s_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            cnt_sh_q     <= cnt_sh_d;
            data_sh_q    <= data_sh_d;
            byte_left_q  <= byte_left_d;
            fetch_left_q <= fetch_left_d;
            buf_full_q   <= buf_full_d;
            buf_data_q   <= buf_data_d;
            aborted_q    <= aborted_d;
        end
    end

endmodule

// File: tb/tb_mssd_frame_tx.sv
// tb/tb_mssd_frame_tx.sv - scoreboard bench for mssd_frame_tx
module tb_mssd_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_port = '0;
    logic [5:0] cmd_count = '0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [7:0] byte_data = '0;
    logic       s_out;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] feed_q[$];
    logic [7:0] frame_bytes[$];
    logic       exp_q[$];
    logic       obs_s[$], obs_fd[$], obs_ur[$], obs_cr[$], obs_br[$];
    logic       fire;

    mssd_frame_tx #(.PORT_W(2), .CNT_W(6), .IDLE_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_port(cmd_port), .cmd_count(cmd_count),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .s_out(s_out), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Byte source: offers the head of feed_q, pops it after a handshake.
    initial begin
        forever begin
            @(negedge clk);
            fire = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (fire && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0) begin
                byte_valid = 1'b1;
                byte_data  = feed_q[0];
            end else begin
                byte_valid = 1'b0;
                byte_data  = '0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obs_s.delete(); obs_fd.delete(); obs_ur.delete();
        obs_cr.delete(); obs_br.delete(); exp_q.delete();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_s.push_back(s_out);
            obs_fd.push_back(frame_done);
            obs_ur.push_back(underrun);
            obs_cr.push_back(cmd_ready);
            obs_br.push_back(byte_ready);
        end
    endtask

    // Expected line bits of one frame, nsent bytes taken from frame_bytes[first..].
    task automatic push_frame(input logic [1:0] p, input logic [5:0] c,
                              input int first, input int nsent);
        logic [7:0] b;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 2; i++) exp_q.push_back(p[i]);
        for (int i = 0; i < 6; i++) exp_q.push_back(c[i]);
        for (int k = 0; k < nsent; k++) begin
            b = frame_bytes[first + k];
            for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        end
        exp_q.push_back(1'b1);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endtask

    task automatic issue_cmd(input logic [1:0] p, input logic [5:0] c, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_port  = p;
        cmd_count = c;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({s_out, busy, byte_ready, frame_done, underrun} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_out: {s_out,busy,byte_ready,frame_done,underrun}=%b required 10000",
                     {s_out, busy, byte_ready, frame_done, underrun});
        end
        #10 rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1 || s_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b s_out=%b required 1 1", cmd_ready, s_out);
        end
    endtask

    task automatic test_three_bytes();
        logic e;
        clear_obs();
        frame_bytes = '{8'hA5, 8'h3C, 8'hFF};
        feed_q = '{8'hA5, 8'h3C, 8'hFF};
        issue_cmd(2'd2, 6'd3, 1'b0);
        push_frame(2'd2, 6'd3, 0, 3);
        push_idle(2);
        capture(36);
        for (int i = 0; i < 36; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_s[i] !== e) begin
                n_fail++;
                $display("FAIL three_bytes_bit[%0d]: s_out=%b required %b", i, obs_s[i], e);
            end
            n_vec++;
            if (obs_fd[i] !== (i == 33) || obs_cr[i] !== (i >= 34) || obs_ur[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL three_bytes_ctl[%0d]: fd=%b cr=%b ur=%b required %b %b 0",
                         i, obs_fd[i], obs_cr[i], obs_ur[i], (i == 33), (i >= 34));
            end
        end
    endtask

    task automatic test_zero_count();
        logic e;
        clear_obs();
        issue_cmd(2'd1, 6'd0, 1'b0);
        push_frame(2'd1, 6'd0, 0, 0);
        push_idle(2);
        capture(12);
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_s[i] !== e) begin
                n_fail++;
                $display("FAIL zero_count_bit[%0d]: s_out=%b required %b", i, obs_s[i], e);
            end
            n_vec++;
            if (obs_fd[i] !== (i == 9) || obs_br[i] !== 1'b0 || obs_cr[i] !== (i >= 10)) begin
                n_fail++;
                $display("FAIL zero_count_ctl[%0d]: fd=%b br=%b cr=%b required %b 0 %b",
                         i, obs_fd[i], obs_br[i], obs_cr[i], (i == 9), (i >= 10));
            end
        end
    endtask

    task automatic test_underrun();
        logic e;
        clear_obs();
        frame_bytes = '{8'h5A};
        feed_q = '{8'h5A};
        issue_cmd(2'd0, 6'd2, 1'b0);
        push_frame(2'd0, 6'd2, 0, 1);
        push_idle(2);
        capture(20);
        for (int i = 0; i < 20; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_s[i] !== e) begin
                n_fail++;
                $display("FAIL underrun_bit[%0d]: s_out=%b required %b", i, obs_s[i], e);
            end
            n_vec++;
            if (obs_ur[i] !== (i == 17) || obs_fd[i] !== 1'b0 || obs_cr[i] !== (i >= 18) ||
                (i >= 17 && obs_br[i] !== 1'b0)) begin
                n_fail++;
                $display("FAIL underrun_ctl[%0d]: ur=%b fd=%b cr=%b br=%b required %b 0 %b 0",
                         i, obs_ur[i], obs_fd[i], obs_cr[i], obs_br[i], (i == 17), (i >= 18));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        clear_obs();
        frame_bytes = '{8'hC3, 8'h81};
        feed_q = '{8'hC3, 8'h81};
        issue_cmd(2'd1, 6'd1, 1'b1);
        push_frame(2'd1, 6'd1, 0, 1);
        push_idle(1);
        push_frame(2'd1, 6'd1, 1, 1);
        push_idle(3);
        capture(18);
        capture(1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        capture(21);
        for (int i = 0; i < 40; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_s[i] !== e) begin
                n_fail++;
                $display("FAIL b2b_bit[%0d]: s_out=%b required %b", i, obs_s[i], e);
            end
            n_vec++;
            if (obs_fd[i] !== (i == 17 || i == 36) || obs_cr[i] !== (i == 18 || i >= 37)) begin
                n_fail++;
                $display("FAIL b2b_ctl[%0d]: fd=%b cr=%b required %b %b",
                         i, obs_fd[i], obs_cr[i], (i == 17 || i == 36), (i == 18 || i >= 37));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic e;
        clear_obs();
        frame_bytes = '{8'h11, 8'h22, 8'h33};
        feed_q = '{8'h11, 8'h22, 8'h33};
        issue_cmd(2'd2, 6'd3, 1'b0);
        push_frame(2'd2, 6'd3, 0, 3);
        capture(11);
        for (int i = 0; i < 11; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_s[i] !== e) begin
                n_fail++;
                $display("FAIL mid_reset_bit[%0d]: s_out=%b required %b", i, obs_s[i], e);
            end
        end
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({s_out, busy, byte_ready, frame_done, underrun} !== 5'b10000) begin
            n_fail++;
            $display("FAIL mid_reset_out: {s_out,busy,byte_ready,frame_done,underrun}=%b required 10000",
                     {s_out, busy, byte_ready, frame_done, underrun});
        end
        #1 rst_n = 1'b1;
        feed_q.delete();
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || s_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_release: cmd_ready=%b busy=%b s_out=%b required 1 0 1",
                     cmd_ready, busy, s_out);
        end
    endtask

    // Receiver-side decode of a port=3, count=4 frame with random payload.
    task automatic test_loopback();
        logic [7:0] sent_q[$];
        logic [1:0] rp;
        logic [5:0] rc;
        logic [7:0] rb;
        logic [7:0] eb;
        int         nfd;
        int         nur;
        clear_obs();
        repeat (2) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            eb = 8'($urandom_range(0, 255));
            sent_q.push_back(eb);
            feed_q.push_back(eb);
        end
        issue_cmd(2'd3, 6'd4, 1'b0);
        capture(44);
        n_vec++;
        if (obs_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_start: s_out=%b required 0", obs_s[0]);
        end
        for (int i = 0; i < 2; i++) rp[i] = obs_s[1 + i];
        for (int i = 0; i < 6; i++) rc[i] = obs_s[3 + i];
        n_vec++;
        if (rp !== 2'd3 || rc !== 6'd4) begin
            n_fail++;
            $display("FAIL loop_hdr: port=%0d count=%0d required 3 4", rp, rc);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) rb[i] = obs_s[9 + 8 * k + i];
            eb = sent_q.pop_front();
            n_vec++;
            if (rb !== eb) begin
                n_fail++;
                $display("FAIL loop_byte[%0d]: got %h required %h", k, rb, eb);
            end
        end
        nfd = 0;
        nur = 0;
        for (int i = 0; i < 44; i++) begin
            if (obs_fd[i] === 1'b1) nfd++;
            if (obs_ur[i] === 1'b1) nur++;
        end
        n_vec++;
        if (obs_s[41] !== 1'b1 || obs_fd[41] !== 1'b1 || nfd != 1 || nur != 0) begin
            n_fail++;
            $display("FAIL loop_end: gap=%b fd=%b n_fd=%0d n_ur=%0d required 1 1 1 0",
                     obs_s[41], obs_fd[41], nfd, nur);
        end
    endtask

    initial begin
        test_reset();
        test_three_bytes();
        test_zero_count();
        test_underrun();
        test_back_to_back();
        test_mid_reset();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
